// File: rtl/video_timing_to_axi4s_core_pkg.sv
// rtl/video_timing_to_axi4s_core_pkg.sv - shared state encoding and FIFO entry layout
package video_timing_to_axi4s_core_pkg;

  // Capture state: IDLE ignores input, RUN forwards pixels, DROP discards until next vsync
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  // FIFO entry layout is {tuser, tlast, tdata}; the two sideband bits sit above the pixel
  localparam int ENT_SIDEBAND_BITS = 2;

endpackage

// File: rtl/video_timing_to_axi4s_core_fifo.sv
// rtl/video_timing_to_axi4s_core_fifo.sv - single-clock first-word-fall-through FIFO
module video_fifo_sync #(
  parameter int WIDTH     = 26,
  parameter int PTR_WIDTH = 10
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int DEPTH = 2 ** PTR_WIDTH;
  localparam logic [PTR_WIDTH-1:0] PTR_ONE = {{(PTR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PTR_WIDTH:0]   CNT_ONE = {{PTR_WIDTH{1'b0}}, 1'b1};

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr;
  logic [PTR_WIDTH-1:0] rd_ptr;
  logic [PTR_WIDTH:0]   count;
  logic                 do_wr;
  logic                 do_rd;

  // count never exceeds DEPTH, so its top bit alone means full
  assign full    = count[PTR_WIDTH];
  assign empty   = (count == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  // head entry is visible without a read request; zero while empty keeps outputs clean
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // storage array, no reset needed since contents are only visible when non-empty
  always_ff @(posedge aclk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // pointers and occupancy; reset flushes the FIFO
  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/video_timing_to_axi4s_core.sv
// rtl/video_timing_to_axi4s_core.sv - raw video timing to AXI4-Stream video converter
module video_timing_to_axi4s_core
  import video_timing_to_axi4s_core_pkg::*;
#(
  parameter int DATA_WIDTH     = 24,
  parameter int FIFO_PTR_WIDTH = 10,
  parameter int H_WIDTH        = 12,
  parameter int V_WIDTH        = 12,
  parameter bit VSYNC_POL      = 1'b1
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  ctl_enable,
  input  logic                  ctl_clear,
  output logic                  ctl_busy,
  output logic                  status_overflow,
  output logic [H_WIDTH-1:0]    status_width,
  output logic [V_WIDTH-1:0]    status_height,
  output logic [15:0]           status_frames,
  input  logic                  in_vsync,
  input  logic                  in_de,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  m_axi4s_tuser,
  output logic                  m_axi4s_tlast,
  output logic [DATA_WIDTH-1:0] m_axi4s_tdata,
  output logic                  m_axi4s_tvalid,
  input  logic                  m_axi4s_tready
);

  localparam int ENT_W = DATA_WIDTH + ENT_SIDEBAND_BITS;
  localparam logic [H_WIDTH-1:0] H_ONE = {{(H_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [V_WIDTH-1:0] V_ONE = {{(V_WIDTH-1){1'b0}}, 1'b1};

  logic                  s1_vs;
  logic                  s1_vs_d;
  logic                  s1_de;
  logic                  s1_de_d;
  logic [DATA_WIDTH-1:0] s1_data;
  logic                  vs_edge;
  logic                  de_fall;

  state_t                state;
  logic                  sof;
  logic                  pend_valid;
  logic [DATA_WIDTH-1:0] pend_data;
  logic                  push_req;
  logic [ENT_W-1:0]      push_ent;
  logic [ENT_W-1:0]      pop_ent;
  logic                  fifo_full;
  logic                  fifo_empty;

  logic [H_WIDTH-1:0]    hcnt;
  logic [H_WIDTH-1:0]    line_width;
  logic [V_WIDTH-1:0]    vcnt;

  assign vs_edge = s1_vs && !s1_vs_d;
  assign de_fall = s1_de_d && !s1_de;

  // the pending pixel goes out whenever a new sample arrives; the new sample decides tlast
  assign push_req = pend_valid && (state == ST_RUN);
  assign push_ent = {sof, (vs_edge || !s1_de), pend_data};

  assign ctl_busy       = (state != ST_IDLE);
  assign m_axi4s_tvalid = !fifo_empty;
  assign m_axi4s_tuser  = pop_ent[DATA_WIDTH+1];
  assign m_axi4s_tlast  = pop_ent[DATA_WIDTH];
  assign m_axi4s_tdata  = pop_ent[DATA_WIDTH-1:0];

  // input stage: register timing with vsync normalised to active-high
  always_ff @(posedge aclk) begin
    if (areset) begin
      s1_vs   <= 1'b0;
      s1_vs_d <= 1'b0;
      s1_de   <= 1'b0;
      s1_de_d <= 1'b0;
      s1_data <= '0;
    end else begin
      s1_vs   <= (in_vsync == VSYNC_POL);
      s1_vs_d <= s1_vs;
      s1_de   <= in_de;
      s1_de_d <= s1_de;
      s1_data <= in_data;
    end
  end

  // state machine with pending pixel, frame-start flag, overflow and frame count
  always_ff @(posedge aclk) begin
    if (areset) begin
      state           <= ST_IDLE;
      sof             <= 1'b0;
      pend_valid      <= 1'b0;
      pend_data       <= '0;
      status_overflow <= 1'b0;
      status_frames   <= '0;
    end else begin
      pend_valid <= s1_de;
      pend_data  <= s1_data;
      if (push_req) begin
        sof <= 1'b0;
      end
      if (ctl_clear) begin
        status_overflow <= 1'b0;
      end
      if (push_req && fifo_full) begin
        status_overflow <= 1'b1;
        state           <= ST_DROP;
      end
      // the old frame's last pixel was handled above in the old state; the edge then re-arms
      if (vs_edge) begin
        if (ctl_enable) begin
          state         <= ST_RUN;
          sof           <= 1'b1;
          status_frames <= status_frames + 16'd1;
        end else begin
          state <= ST_IDLE;
          sof   <= 1'b0;
        end
      end
    end
  end

  // line and frame geometry counters, latched into status at each vsync edge
  always_ff @(posedge aclk) begin
    if (areset) begin
      hcnt          <= '0;
      line_width    <= '0;
      vcnt          <= '0;
      status_width  <= '0;
      status_height <= '0;
    end else begin
      if (de_fall) begin
        line_width <= hcnt;
        hcnt       <= '0;
        vcnt       <= vcnt + V_ONE;
      end else if (s1_de) begin
        hcnt <= hcnt + H_ONE;
      end
      if (vs_edge) begin
        status_width  <= line_width;
        status_height <= vcnt;
        vcnt          <= '0;
      end
    end
  end

  video_fifo_sync #(
    .WIDTH    (ENT_W),
    .PTR_WIDTH(FIFO_PTR_WIDTH)
  ) u_fifo (
    .aclk   (aclk),
    .areset (areset),
    .wr_en  (push_req),
    .wr_data(push_ent),
    .full   (fifo_full),
    .rd_en  (m_axi4s_tvalid && m_axi4s_tready),
    .rd_data(pop_ent),
    .empty  (fifo_empty)
  );

endmodule
